// File: rtl/data_rw_pkg.sv
// Shared constants, state encoding and address helper for the LVDS capture/playback buffers.
package data_rw_pkg;

    localparam int BUF_BITS = 8192;
    localparam int NUM_CH   = 4;
    localparam int WORD_AW  = 8;
    localparam int LEN_W    = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RUN   = 2'd2
    } state_e;

    // Word index holding a given bit position (bit n lives in word n/32).
    function automatic logic [WORD_AW-1:0] word_of(input logic [LEN_W-1:0] bit_pos);
        return WORD_AW'(bit_pos >> 5);
    endfunction

endpackage

// File: rtl/data_write_player_if.sv
// Host write port, playback control and serial output bundle of the data write player.
interface data_write_player_if #(
    parameter int WORD_AW = 8,
    parameter int LEN_W   = 14
);
    logic [WORD_AW-1:0] wr_addr;
    logic [1:0]         wr_sel;
    logic [31:0]        wr_data;
    logic               wr_en;
    logic [LEN_W-1:0]   play_len;
    logic               loop;
    logic               start;
    logic               stop;
    logic               bit_strobe;
    logic [3:0]         tx_data;
    logic               tx_valid;
    logic               busy;
    logic               done;

    modport master (
        output wr_addr, wr_sel, wr_data, wr_en, play_len, loop, start, stop, bit_strobe,
        input  tx_data, tx_valid, busy, done
    );

    modport slave (
        input  wr_addr, wr_sel, wr_data, wr_en, play_len, loop, start, stop, bit_strobe,
        output tx_data, tx_valid, busy, done
    );
endinterface

// File: rtl/data_write_ram.sv
// One write / one registered read synchronous RAM; one instance per playback channel.
module data_write_ram #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rd_data_q;

    // No reset on storage or read register so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/data_write_player.sv
// Plays four host-loaded bit buffers out serially, one bit per channel per bit strobe.
module data_write_player #(
    parameter int BUF_BITS = data_rw_pkg::BUF_BITS,
    parameter int WORD_AW  = data_rw_pkg::WORD_AW,
    parameter int LEN_W    = data_rw_pkg::LEN_W
) (
    input  logic               clk,
    input  logic               rst,
    data_write_player_if.slave bus
);
    import data_rw_pkg::*;

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_FETCH = FETCH;
    localparam logic [1:0] S_RUN   = RUN;

    logic [1:0]              state_q, state_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [LEN_W-1:0]        bit_pos_q, bit_pos_d;
    logic                    loop_q, loop_d;
    logic                    reload_q, reload_d;
    logic [NUM_CH-1:0][31:0] shift_q, shift_d;
    logic [NUM_CH-1:0]       tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    done_q, done_d;
    logic [31:0]             rd_data [NUM_CH];
    logic [WORD_AW-1:0]      rd_addr;
    logic                    len_ok;
    logic                    last_bit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ram
            data_write_ram #(.AW(WORD_AW), .DW(32)) u_ram (
                .clk    (clk),
                .we     (bus.wr_en && (bus.wr_sel == 2'(gi))),
                .wr_addr(bus.wr_addr),
                .wr_data(bus.wr_data),
                .rd_addr(rd_addr),
                .rd_data(rd_data[gi])
            );
        end
    endgenerate

    assign len_ok   = (bus.play_len != '0) && (bus.play_len <= LEN_W'(BUF_BITS));
    assign last_bit = (bit_pos_q == len_q - 1'b1);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        loop_d     = loop_q;
        bit_pos_d  = bit_pos_q;
        shift_d    = shift_q;
        reload_d   = 1'b0;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        done_d     = 1'b0;
        rd_addr    = '0;

        if (bus.stop) begin
            state_d    = S_IDLE;
            tx_data_d  = '0;
            tx_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start && len_ok) begin
                        len_d   = bus.play_len;
                        loop_d  = bus.loop;
                        rd_addr = '0;
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        shift_d[ch] = rd_data[ch];
                    end
                    bit_pos_d = '0;
                    state_d   = S_RUN;
                end
                S_RUN: begin
                    // Refill lands one cycle after the read; strobe spacing keeps it clear of the next strobe.
                    if (reload_q) begin
                        for (int ch = 0; ch < NUM_CH; ch++) begin
                            shift_d[ch] = rd_data[ch];
                        end
                    end
                    if (bus.bit_strobe) begin
                        if (bit_pos_q < len_q) begin
                            for (int ch = 0; ch < NUM_CH; ch++) begin
                                tx_data_d[ch] = shift_q[ch][0];
                                shift_d[ch]   = shift_q[ch] >> 1;
                            end
                            tx_valid_d = 1'b1;
                            if (loop_q && last_bit) begin
                                bit_pos_d = '0;
                                rd_addr   = '0;
                                reload_d  = 1'b1;
                            end else begin
                                bit_pos_d = bit_pos_q + 1'b1;
                                if (&bit_pos_q[4:0]) begin
                                    rd_addr  = word_of(bit_pos_d);
                                    reload_d = 1'b1;
                                end
                            end
                        end else begin
                            tx_data_d  = '0;
                            tx_valid_d = 1'b0;
                            done_d     = 1'b1;
                            state_d    = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            loop_q     <= 1'b0;
            bit_pos_q  <= '0;
            reload_q   <= 1'b0;
            shift_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            loop_q     <= loop_d;
            bit_pos_q  <= bit_pos_d;
            reload_q   <= reload_d;
            shift_q    <= shift_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            done_q     <= done_d;
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
endmodule

// File: tb/tb_data_write_player.sv
// Randomized self-checking bench for data_write_player against a word-array playback model.
module tb_data_write_player;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] mem_m [4][256];

    data_write_player_if #(.WORD_AW(8), .LEN_W(14)) bus ();

    data_write_player dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] model_nib(input int p);
        logic [3:0]  n;
        logic [31:0] w;
        for (int ch = 0; ch < 4; ch++) begin
            w     = mem_m[ch][p / 32];
            n[ch] = w[p % 32];
        end
        return n;
    endfunction

    task automatic host_write(input int ch, input int wa, input logic [31:0] v);
        logic [1:0] sel;
        logic [7:0] adr;
        sel = ch[1:0];
        adr = wa[7:0];
        bus.wr_sel  = sel;
        bus.wr_addr = adr;
        bus.wr_data = v;
        bus.wr_en   = 1'b1;
        mem_m[ch][wa] = v;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    // Starts playback and checks {busy, tx_valid, done, tx_data} after every strobe.
    task automatic run_play(input int len, input bit lp, input int nstr, input int sp,
                            input int wr_k, input int wr_ch, input int wr_w,
                            input logic [31:0] wr_v, input string nm);
        logic [3:0] expq [$];
        logic [3:0] tmp;
        logic [6:0] got, exp;
        logic [13:0] plen;
        for (int p = 0; p < len; p++) expq.push_back(model_nib(p));
        plen = len[13:0];
        bus.play_len = plen;
        bus.loop     = lp;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_after_start got=%b want=1", nm, bus.busy);
        end
        @(negedge clk);
        for (int k = 0; k < nstr; k++) begin
            bus.bit_strobe = 1'b1;
            @(negedge clk);
            bus.bit_strobe = 1'b0;
            got = {bus.busy, bus.tx_valid, bus.done, bus.tx_data};
            if (!lp && k == len) exp = 7'b0010000;
            else                 exp = {3'b110, expq[k % len]};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s strobe%0d {busy,valid,done,data} got=%b want=%b", nm, k, got, exp);
            end
            if (k == wr_k) begin
                bus.wr_sel  = wr_ch[1:0];
                bus.wr_addr = wr_w[7:0];
                bus.wr_data = wr_v;
                bus.wr_en   = 1'b1;
                // Only words whose fetch is still ahead pick up the new value.
                if (32 * wr_w - 1 > k) begin
                    for (int p = 32 * wr_w; p < 32 * wr_w + 32 && p < len; p++) begin
                        tmp        = expq[p];
                        tmp[wr_ch] = wr_v[p - 32 * wr_w];
                        expq[p]    = tmp;
                    end
                end
                mem_m[wr_ch][wr_w] = wr_v;
            end
            repeat (sp - 1) begin
                @(negedge clk);
                bus.wr_en = 1'b0;
            end
        end
        if (!lp && nstr == len + 1) begin
            n_tests++;
            if ({bus.busy, bus.done} !== 2'b00) begin
                n_fail++;
                $display("FAIL %s idle_after_done {busy,done} got=%b want=00", nm, {bus.busy, bus.done});
            end
        end
    endtask

    task automatic do_stop(input string nm);
        bus.stop       = 1'b1;
        bus.bit_strobe = 1'b1;
        @(negedge clk);
        bus.stop       = 1'b0;
        bus.bit_strobe = 1'b0;
        n_tests++;
        if ({bus.busy, bus.tx_valid, bus.done, bus.tx_data} !== 7'b0) begin
            n_fail++;
            $display("FAIL %s stop got=%b want=0000000", nm,
                     {bus.busy, bus.tx_valid, bus.done, bus.tx_data});
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.wr_addr = '0; bus.wr_sel = '0; bus.wr_data = '0; bus.wr_en = 1'b0;
        bus.play_len = '0; bus.loop = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
        bus.bit_strobe = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({bus.busy, bus.tx_valid, bus.done, bus.tx_data} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_state got=%b want=0000000",
                     {bus.busy, bus.tx_valid, bus.done, bus.tx_data});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic fill_index();
        for (int w = 0; w < 256; w++)
            for (int ch = 0; ch < 4; ch++) host_write(ch, w, 32'(w));
    endtask

    task automatic test_basic();
        host_write(0, 0, 32'h0000_0005);
        for (int ch = 1; ch < 4; ch++) host_write(ch, 0, 32'h0);
        run_play(4, 1'b0, 5, 4, -1, 0, 0, 32'h0, "basic");
    endtask

    task automatic test_word_boundary();
        for (int ch = 0; ch < 4; ch++) begin
            host_write(ch, 0, 32'hFFFF_FFFF);
            host_write(ch, 1, 32'h0000_0001);
        end
        run_play(33, 1'b0, 34, 2, -1, 0, 0, 32'h0, "word_boundary");
    endtask

    task automatic test_loop();
        for (int ch = 0; ch < 3; ch++) host_write(ch, 0, $urandom);
        host_write(3, 0, 32'h0000_0002);
        run_play(3, 1'b1, 9, 3, -1, 0, 0, 32'h0, "loop");
        do_stop("loop");
    endtask

    task automatic test_boundary();
        fill_index();
        run_play(8192, 1'b0, 8193, 2, -1, 0, 0, 32'h0, "len_max");
        for (int i = 0; i < 2; i++) begin
            bus.play_len = (i == 0) ? 14'd0 : 14'd8193;
            bus.start    = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            @(negedge clk);
            n_tests++;
            if (bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL bad_len%0d busy got=%b want=0", bus.play_len, bus.busy);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        run_play(200, 1'b0, 101, 2, -1, 0, 0, 32'h0, "pre_reset");
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.busy, bus.tx_valid, bus.done, bus.tx_data} !== 7'b0) begin
            n_fail++;
            $display("FAIL async_reset got=%b want=0000000",
                     {bus.busy, bus.tx_valid, bus.done, bus.tx_data});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_play(200, 1'b0, 201, 2, -1, 0, 0, 32'h0, "post_reset");
    endtask

    task automatic test_start_stop_idle();
        bus.play_len = 14'd10;
        bus.loop     = 1'b0;
        bus.start    = 1'b1;
        bus.stop     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.bit_strobe = 1'b1;
            @(negedge clk);
            bus.bit_strobe = 1'b0;
            @(negedge clk);
            n_tests++;
            if ({bus.busy, bus.tx_valid} !== 2'b00) begin
                n_fail++;
                $display("FAIL start_stop_idle%0d {busy,valid} got=%b want=00", i, {bus.busy, bus.tx_valid});
            end
        end
    endtask

    task automatic test_host_write_run();
        for (int w = 0; w < 8; w++)
            for (int ch = 0; ch < 4; ch++) host_write(ch, w, $urandom);
        run_play(256, 1'b0, 257, 4, 40, 2, 5, ~mem_m[2][5], "write_new");
        run_play(256, 1'b0, 257, 4, 45, 1, 1, ~mem_m[1][1], "write_old");
    endtask

    task automatic test_random();
        int len, sp, nstr;
        bit lp;
        for (int it = 0; it < 6; it++) begin
            len = $urandom_range(1, 300);
            lp  = 1'($urandom_range(0, 1));
            sp  = $urandom_range(2, 5);
            nstr = lp ? len + $urandom_range(1, 40) : len + 1;
            for (int w = 0; w <= (len - 1) / 32; w++)
                for (int ch = 0; ch < 4; ch++) host_write(ch, w, $urandom);
            run_play(len, lp, nstr, sp, -1, 0, 0, 32'h0, $sformatf("random%0d", it));
            if (lp) do_stop($sformatf("random%0d", it));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_word_boundary();
        test_loop();
        test_boundary();
        test_reset_mid_run();
        test_start_stop_idle();
        test_host_write_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/data_write_player.md
Name: data_write_player

Overview:
- Transmit-side counterpart of the LVDS capture buffer: the host loads four per-channel bit buffers (8192 bits each) through a 32-bit word port.
- The block then plays the buffers out serially, one bit per channel per bit strobe, on a 4-bit LVDS output bus.
- Sits between the processor bus register interface and the LVDS output serializers/ODDRs.
- Supports one-shot and continuous loop playback with abort.

Parameters:
BUF_BITS, 8192, bits stored per channel (power of two, multiple of 32)
WORD_AW, 8, word address width = log2(BUF_BITS/32)
LEN_W, 14, width of play_len (must hold BUF_BITS)

Ports:
clk  in  1  single clock for host and playback logic
rst  in  1  asynchronous, active-high reset
wr_addr  in  WORD_AW  host word address within selected channel buffer
wr_sel  in  2  channel select 0..3
wr_data  in  32  host word; bit 0 = earliest played bit
wr_en  in  1  write strobe, one word per cycle
play_len  in  LEN_W  bits to play per channel, 1..BUF_BITS
loop  in  1  1 = wrap to bit 0 after last bit
start  in  1  1-cycle pulse, begin playback
stop  in  1  1-cycle pulse, abort playback
bit_strobe  in  1  bit-rate enable; at least one low cycle between highs
tx_data  out  4  serial bit per channel, [i] = channel i
tx_valid  out  1  tx_data carries playback data
busy  out  1  state != IDLE
done  out  1  1-cycle pulse at normal one-shot completion

Behaviour:
- Reset (async, rst=1): state IDLE, tx_data=0, tx_valid=0, busy=0, done=0, counters 0. Buffer contents not cleared.
- Storage: 4 simple dual-port RAMs of (BUF_BITS/32) x 32.
  - Write port: wr_en writes wr_data to RAM[wr_sel][wr_addr], accepted in any state.
  - Read port: one shared address to all 4 RAMs; data is registered, 1-cycle latency.
- Bit ordering: bit n of a channel = word n[12:5], bit n[4:0].
- States:
  - IDLE
    - start=1 and play_len in 1..BUF_BITS: latch len and loop; issue read addr 0; go FETCH.
    - start with play_len=0 or >BUF_BITS: ignored.
  - FETCH, one cycle: load 4x32 shift regs from RAM output; bit_pos=0; go RUN. busy=1 from the cycle after start.
  - RUN, on each bit_strobe:
    - bit_pos < len: drive tx_data[i]=shift_i[0], tx_valid=1, shift regs right by 1, bit_pos++.
    - If the consumed bit was bit 31 of a word, or the final bit with loop=1: issue read of next word address.
      - Next address = (bit_pos+1)[12:5], or 0 on wrap.
      - Load the shift regs on the next cycle; strobe spacing guarantees the data is ready.
    - Loop wrap: after bit len-1, bit_pos returns to 0 with no gap strobe. Loop continues until stop.
    - One-shot end: the strobe after bit len-1 was presented sets tx_valid=0, tx_data=0, done=1 for 1 cycle, state IDLE. Each bit is therefore held exactly one strobe period.
- Register timing: tx_data/tx_valid update the cycle after the strobe.
- stop: any state -> IDLE next cycle; tx_data=0, tx_valid=0, no done.
- Priority rules:
  - stop wins over a simultaneous strobe.
  - start while busy is ignored.
  - start and stop together in IDLE: stop wins, no playback.
- Host writes during RUN are allowed. A word written before it is fetched plays the new value; otherwise the old value plays.
- play_len/loop changes during RUN have no effect until the next start.
- bit_strobe in IDLE/FETCH is ignored. A strobe arriving in FETCH is dropped, not queued.

Decomposition:
- Shared package data_rw_pkg:
  - BUF_BITS and NUM_CH=4 constants, also consumed by the capture buffer.
  - State enum {IDLE, FETCH, RUN}.
  - Function word_of(bit_pos).
- One sub-module: data_write_ram, a 1W/1R synchronous 32-bit RAM instantiated 4x for BRAM inference.

Test Plan:
- Load ch0 word0=0x0000_0005, others 0; len=4, loop=0, start, strobe every 4 clk.
  -> tx_data[0] = 1,0,1,0 on successive strobes; tx_valid high 4 strobes; done pulse on 5th strobe; busy low after.
- Load words 0,1 of all channels with 0xFFFF_FFFF, 0x0000_0001; len=33.
  -> 32 ones then one 1 on bit 32. Verifies word-boundary refetch at max rate (strobe every 2 clk); no done before strobe 34.
- Loop: ch3 word0=0x2 (bits 0,1,0), len=3, loop=1, run 9 strobes.
  -> tx_data[3] = 0,1,0 repeated three times with no gap; no done; stop -> tx_valid=0 next cycle, no done.
- Boundary: len=8192, one-shot, all words = index.
  -> last word played is 0xFF per channel; done after strobe 8193. len=0 or 8193 with start -> busy stays 0.
- Reset mid-RUN at bit 100: outputs 0 in the same cycle (async). A new start after release replays from bit 0 with unchanged buffer contents.
- Simultaneous events:
  - start+stop in IDLE -> no playback.
  - Host write to word 5 while bit 40 is playing -> new value heard at bit 160.
  - Host write to word 1 during bits 40..63 -> old value kept.
